// File: rtl/load_store_unit.sv
`default_nettype none
// =============================================================================
// load_store_unit : big-endian load/store engine, sub-word stores done as RMW.
// Rev 1.0 -- define MISALIGN_TRAP_EN to enable the misaligned-access FAULT path.
// =============================================================================
module load_store_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] fault_addr,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
`ifdef MISALIGN_TRAP_EN
    S_FAULT,
`endif
    S_RESP
  } state_t;

  state_t      state, state_n;
  logic [2:0]  op_q;
  logic [31:0] addr_q, cur_addr;
  logic [15:0] wdata_q;
  logic [2:0]  cnt;
  logic        accept, is_sub_store, to_fault;

  assign req_ready    = (state == S_IDLE) && reset;
  assign accept       = req_valid && req_ready;
  assign cur_addr     = (state == S_IDLE) ? req_addr : addr_q;
  assign is_sub_store = (op_q == OP_SH) || (op_q == OP_SB);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    case (req_op)
      OP_LW, OP_SW:         misaligned = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
      default:              misaligned = 1'b0;
    endcase
  end
  assign to_fault = (state_n == S_FAULT);
`else
  assign to_fault = 1'b0;
`endif

  // Offset 0 is the most significant byte (big-endian).
  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (op)
      OP_LH:   extract = {{16{h[15]}}, h};
      OP_LHU:  extract = {16'h0000, h};
      OP_LB:   extract = {{24{b[7]}}, b};
      OP_LBU:  extract = {24'h000000, b};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] off,
                                        input logic [31:0] w, input logic [15:0] d);
    logic [31:0] m;
    m = w;
    if (op == OP_SH) begin
      if (off[1]) m[15:0] = d;
      else        m[31:16] = d;
    end else begin
      case (off)
        2'd0:    m[31:24] = d[7:0];
        2'd1:    m[23:16] = d[7:0];
        2'd2:    m[15:8]  = d[7:0];
        default: m[7:0]   = d[7:0];
      endcase
    end
    merge = m;
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = (req_op == OP_SW) ? S_WRITE : S_READ;
`ifdef MISALIGN_TRAP_EN
          if (misaligned) state_n = S_FAULT;
`endif
        end
      end
      S_READ:  if (cnt == 3'd1) state_n = is_sub_store ? S_WRITE : S_RESP;
      S_WRITE: state_n = S_RESP;
      default: state_n = S_IDLE;
    endcase
  end

  // All memory/response outputs are registered from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      fault_addr <= '0;
    end else begin
      state      <= state_n;
      mem_wr     <= (state_n == S_WRITE);
      mem_addr   <= (state_n == S_READ || state_n == S_WRITE) ? {cur_addr[31:2], 2'b00} : '0;
      resp_valid <= (state_n == S_RESP) || to_fault;
      resp_fault <= to_fault;
      if (to_fault) fault_addr <= req_addr;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata[15:0];
        cnt     <= 3'(MEM_LAT);
      end else if (state == S_READ) begin
        cnt <= cnt - 3'd1;
      end
      if (state == S_IDLE && state_n == S_WRITE) mem_wdata <= req_wdata;
      if (state == S_READ && cnt == 3'd1) begin
        if (is_sub_store) mem_wdata  <= merge(op_q, addr_q[1:0], mem_rdata, wdata_q);
        else              resp_rdata <= extract(op_q, addr_q[1:0], mem_rdata);
      end
      if (state == S_WRITE) resp_rdata <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit : scoreboard bench, two instances (MEM_LAT 1 and 3) driven in lockstep.
module tb_load_store_unit;

  localparam int N = 2;
  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
  localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] faddr;
    logic [3:0]  lat;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic [N-1:0] vld;
  logic [2:0]   op;
  logic [31:0]  addr, wdata;
  logic [N-1:0] ready, rvalid, rfault, mwr;
  logic [31:0]  rdata [N];
  logic [31:0]  faddr [N];
  logic [31:0]  maddr [N];
  logic [31:0]  mwdata[N];
  logic [31:0]  mrdata[N];

  resp_t exp_q[N][$];
  wr_t   wr_q [N][$];
  int    acc_q[N][$];
  logic [31:0] last_rd [N];
  logic        rd_known[N];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [31:0] word100;
    logic [31:0] apipe[0:6];
    logic        stable;

    load_store_unit #(.MEM_LAT(LAT)) dut (
      .clock(clock), .reset(reset),
      .req_valid(vld[gi]), .req_ready(ready[gi]),
      .req_op(op), .req_addr(addr), .req_wdata(wdata),
      .resp_valid(rvalid[gi]), .resp_rdata(rdata[gi]),
      .resp_fault(rfault[gi]), .fault_addr(faddr[gi]),
      .mem_addr(maddr[gi]), .mem_wr(mwr[gi]), .mem_wdata(mwdata[gi]),
      .mem_rdata(mrdata[gi])
    );

    initial word100 = 32'h8899AABB;

    always @(posedge clock) begin
      if (mwr[gi] && maddr[gi] == 32'h100) word100 <= mwdata[gi];
      apipe[0] <= maddr[gi];
      for (int i = 1; i < 7; i++) apipe[i] <= apipe[i-1];
    end

    // Data is only valid once the address has been held for LAT cycles.
    always_comb begin
      stable = 1'b1;
      for (int i = 0; i < LAT - 1; i++)
        if (apipe[i] !== maddr[gi]) stable = 1'b0;
    end
    assign mrdata[gi] = (stable && maddr[gi] == 32'h100) ? word100 : 32'hDEADDEAD;
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (MEM_LAT=%0d) at cycle %0d: got %h, expected %h",
               name, (k == 0) ? 1 : 3, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      for (int k = 0; k < N; k++) begin
        resp_t e;
        wr_t   w;
        int    a;
        chk("ready_during_resp", k, {31'b0, ready[k] & rvalid[k]}, 32'h0);
        if (vld[k] && ready[k]) acc_q[k].push_back(cyc + 1);
        if (mwr[k]) begin
          if (wr_q[k].size() == 0) begin
            chk("unexpected_write", k, {31'b0, mwr[k]}, 32'h0);
          end else begin
            w = wr_q[k].pop_front();
            chk("write_addr", k, maddr[k], w.addr);
            chk("write_data", k, mwdata[k], w.data);
          end
        end
        if (rvalid[k]) begin
          if (exp_q[k].size() == 0) begin
            chk("unexpected_resp", k, {31'b0, rvalid[k]}, 32'h0);
          end else begin
            e = exp_q[k].pop_front();
            a = (acc_q[k].size() != 0) ? acc_q[k].pop_front() : -100;
            // latency counted to the edge that closes the resp_valid cycle
            chk("latency", k, cyc + 1 - a, {28'b0, e.lat});
            chk("resp_fault", k, {31'b0, rfault[k]}, {31'b0, e.fault});
            if (e.fault) begin
              chk("fault_addr", k, faddr[k], e.faddr);
              rd_known[k] = 1'b0;
            end else begin
              chk("resp_rdata", k, rdata[k], e.rdata);
              last_rd[k]  = e.rdata;
              rd_known[k] = 1'b1;
            end
          end
        end else if (rd_known[k]) begin
          chk("rdata_hold", k, rdata[k], last_rd[k]);
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_mem_wr", k, {31'b0, mwr[k]}, 32'h0);
      chk("rst_req_ready", k, {31'b0, ready[k]}, 32'h0);
      chk("rst_resp_valid", k, {31'b0, rvalid[k]}, 32'h0);
      chk("rst_resp_fault", k, {31'b0, rfault[k]}, 32'h0);
      chk("rst_mem_addr", k, maddr[k], 32'h0);
      chk("rst_mem_wdata", k, mwdata[k], 32'h0);
      chk("rst_resp_rdata", k, rdata[k], 32'h0);
      chk("rst_fault_addr", k, faddr[k], 32'h0);
    end
    repeat (cycles) @(negedge clock);
    for (int k = 0; k < N; k++) begin
      acc_q[k].delete();
      last_rd[k]  = 32'h0;
      rd_known[k] = 1'b1;
    end
    reset = 1'b1;
    #1;
    for (int k = 0; k < N; k++) chk("ready_after_reset", k, {31'b0, ready[k]}, 32'h1);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(posedge clock); #1;
    while (ready != '1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (ready != '1) chk("issue_timeout", 0, {30'b0, ready}, 32'h3);
    op = o; addr = a; wdata = d; vld = '1;
    @(posedge clock); #1;
    vld = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      chk("resp_timeout", 0, exp_q[0].size() + exp_q[1].size(), 32'h0);
      for (int k = 0; k < N; k++) exp_q[k].delete();
    end
  endtask

  task automatic expect_resp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] rd,
                             input logic flt, input logic do_wr, input logic [31:0] wd);
    int lt;
    for (int k = 0; k < N; k++) begin
      int l = (k == 0) ? 1 : 3;
      if (flt)                        lt = 1;
      else if (o == SW)               lt = 2;
      else if (o == SH || o == SB)    lt = l + 2;
      else                            lt = l + 1;
      exp_q[k].push_back('{rdata: rd, fault: flt, faddr: a, lat: 4'(lt)});
      if (do_wr) wr_q[k].push_back('{addr: 32'h100, data: wd});
    end
  endtask

  task automatic load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] rd);
    expect_resp(o, a, rd, 1'b0, 1'b0, 32'h0);
    issue(o, a, 32'h0);
    wait_done();
  endtask

  task automatic store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] new_word);
    expect_resp(o, a, 32'h0, 1'b0, 1'b1, new_word);
    issue(o, a, d);
    wait_done();
  endtask

  task automatic fault(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    expect_resp(o, a, 32'h0, 1'b1, 1'b0, 32'h0);
    issue(o, a, d);
    wait_done();
  endtask

  // req_valid stays high through the busy cycles; the second request is
  // taken only once each instance is back in IDLE.
  task automatic held_pair();
    logic [N-1:0] take;
    int n = 0;
    expect_resp(LB,  32'h101, 32'hFFFFFF80, 1'b0, 1'b0, 32'h0);
    expect_resp(LBU, 32'h103, 32'h00000066, 1'b0, 1'b0, 32'h0);
    @(posedge clock); #1;
    op = LB; addr = 32'h101; wdata = 32'h0; vld = '1;
    @(posedge clock); #1;
    op = LBU; addr = 32'h103; wdata = 32'hFFFFFFFF;
    while (vld != '0 && n < 60) begin
      take = vld & ready;
      @(posedge clock); #1;
      vld = vld & ~take;
      n++;
    end
    if (vld != '0) chk("held_accept_timeout", 0, {30'b0, vld}, 32'h0);
    vld = '0;
    wait_done();
  endtask

  initial begin
    vld = '0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    for (int k = 0; k < N; k++) begin
      rd_known[k] = 1'b0;
      last_rd[k]  = 32'h0;
    end
    do_reset(4);

    load(LB,  32'h101, 32'hFFFFFF99);
    load(LBU, 32'h101, 32'h00000099);
    load(LH,  32'h100, 32'hFFFF8899);
    load(LHU, 32'h102, 32'h0000AABB);
    load(LB,  32'h103, 32'hFFFFFFBB);
    load(LBU, 32'h100, 32'h00000088);
    load(LW,  32'h100, 32'h8899AABB);

    // SH aborted by reset while reading: no write, no response
    issue(SH, 32'h102, 32'h00001234);
    do_reset(3);
    load(LW, 32'h100, 32'h8899AABB);

    store(SB, 32'h103, 32'h12345677, 32'h8899AA77);
    load(LW, 32'h100, 32'h8899AA77);
    store(SW, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    load(LW, 32'h100, 32'hDEADBEEF);
    store(SH, 32'h102, 32'hFFFF5566, 32'hDEAD5566);
    load(LH,  32'h102, 32'h00005566);
    load(LHU, 32'h100, 32'h0000DEAD);
    load(LH,  32'h100, 32'hFFFFDEAD);
    store(SB, 32'h100, 32'h0000007F, 32'h7FAD5566);
    load(LB,  32'h100, 32'h0000007F);
    store(SB, 32'h101, 32'hFFFFFF80, 32'h7F805566);
    load(LB,  32'h101, 32'hFFFFFF80);
    load(LBU, 32'h101, 32'h00000080);

    held_pair();

`ifdef MISALIGN_TRAP_EN
    fault(LW,  32'h102, 32'h0);
    fault(SH,  32'h103, 32'h0000ABCD);
    fault(LHU, 32'h101, 32'h0);
    fault(LH,  32'h103, 32'h0);
    fault(SW,  32'h101, 32'hDEADBEEF);
    load(LW, 32'h100, 32'h7F805566);
`else
    load(LW, 32'h102, 32'h7F805566);
    store(SH, 32'h103, 32'h0000ABCD, 32'h7F80ABCD);
    load(LHU, 32'h101, 32'h00007F80);
    load(LH,  32'h103, 32'hFFFFABCD);
    store(SW, 32'h101, 32'hDEADBEEF, 32'hDEADBEEF);
    load(LW, 32'h100, 32'hDEADBEEF);
`endif

    repeat (3) @(posedge clock);
    for (int k = 0; k < N; k++) chk("pending_writes", k, wr_q[k].size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
